// File: rtl/trap_probe.sv
// Probes the four bounding-box corners of the robot against the trap lookup
// and reports the first trapped corner (in corner order) with its colour.
module trap_probe #(
  parameter int ROBO_W  = 8,
  parameter int ROBO_H  = 8,
  parameter int LATENCY = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [8:0] robot_x,
  input  logic [8:0] robot_y,
  input  logic [2:0] flag,
  output logic [8:0] x_cord,
  output logic [8:0] y_cord,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [2:0] hit_colour,
  output logic [1:0] hit_corner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROBE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [9:0] W_OFF    = 10'(ROBO_W - 1);
  localparam logic [9:0] H_OFF    = 10'(ROBO_H - 1);
  localparam logic [2:0] LAT      = 3'(LATENCY);
  localparam logic [2:0] LAST_CYC = 3'(3 + LATENCY);

  // Far-edge coordinate saturates at the screen edge instead of wrapping.
  function automatic logic [8:0] clamp_add(input logic [8:0] base, input logic [9:0] off);
    logic [9:0] sum;
    sum = {1'b0, base} + off;
    if (sum > 10'd511) begin
      clamp_add = 9'd511;
    end else begin
      clamp_add = sum[8:0];
    end
  endfunction

  logic [1:0] state_r;
  logic [2:0] cyc_r;
  logic [8:0] base_x_r;
  logic [8:0] base_y_r;
  logic       work_hit_r;
  logic [2:0] work_colour_r;
  logic [1:0] work_corner_r;

  logic [8:0] far_x_s;
  logic [8:0] far_y_s;
  logic [1:0] nxt_corner_s;
  logic [8:0] corner_x_s;
  logic [8:0] corner_y_s;
  logic       samp_valid_s;
  logic [1:0] samp_corner_s;
  logic       publish_s;
  logic       work_hit_s;
  logic [2:0] work_colour_s;
  logic [1:0] work_corner_s;

  assign far_x_s = clamp_add(base_x_r, W_OFF);
  assign far_y_s = clamp_add(base_y_r, H_OFF);

  // Next corner to drive; corner index bit0 selects far x, bit1 selects far y.
  always_comb begin
    nxt_corner_s = cyc_r[1:0] + 2'd1;
    corner_x_s   = nxt_corner_s[0] ? far_x_s : base_x_r;
    corner_y_s   = nxt_corner_s[1] ? far_y_s : base_y_r;
  end

  // Which corner's flag arrives on this edge, and whether it is the last one.
  always_comb begin
    samp_valid_s  = 1'b0;
    samp_corner_s = 2'd0;
    publish_s     = 1'b0;
    if (state_r == ST_PROBE) begin
      samp_valid_s  = (cyc_r >= LAT) && ((cyc_r - LAT) <= 3'd3);
      samp_corner_s = 2'(cyc_r - LAT);
      publish_s     = (cyc_r == LAST_CYC);
    end else begin
      samp_valid_s  = 1'b0;
      samp_corner_s = 2'd0;
      publish_s     = 1'b0;
    end
  end

  // Working result: only the first nonzero corner is recorded.
  always_comb begin
    work_hit_s    = work_hit_r;
    work_colour_s = work_colour_r;
    work_corner_s = work_corner_r;
    if (samp_valid_s && !work_hit_r && (flag != 3'b000)) begin
      work_hit_s    = 1'b1;
      work_colour_s = flag;
      work_corner_s = samp_corner_s;
    end else begin
      work_hit_s    = work_hit_r;
      work_colour_s = work_colour_r;
      work_corner_s = work_corner_r;
    end
  end

  // Probe sequencer, query port and published results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      cyc_r         <= 3'd0;
      base_x_r      <= 9'd0;
      base_y_r      <= 9'd0;
      work_hit_r    <= 1'b0;
      work_colour_r <= 3'd0;
      work_corner_r <= 2'd0;
      x_cord        <= 9'd0;
      y_cord        <= 9'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hit           <= 1'b0;
      hit_colour    <= 3'd0;
      hit_corner    <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_x_r      <= robot_x;
            base_y_r      <= robot_y;
            x_cord        <= robot_x;
            y_cord        <= robot_y;
            cyc_r         <= 3'd0;
            busy          <= 1'b1;
            work_hit_r    <= 1'b0;
            work_colour_r <= 3'd0;
            work_corner_r <= 2'd0;
            state_r       <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          cyc_r         <= cyc_r + 3'd1;
          work_hit_r    <= work_hit_s;
          work_colour_r <= work_colour_s;
          work_corner_r <= work_corner_s;
          if (cyc_r < 3'd3) begin
            x_cord <= corner_x_s;
            y_cord <= corner_y_s;
          end
          if (publish_s) begin
            hit        <= work_hit_s;
            hit_colour <= work_colour_s;
            hit_corner <= work_corner_s;
            done       <= 1'b1;
            busy       <= 1'b0;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
